// File: rtl/fpu_sequencer.sv
// Issue/sequencing controller between CPU decode and the FPU datapath: accepts one FP op,
// holds its operand fields for the op latency, then strobes a single register-file write.
module fpu_sequencer #(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 5,
    parameter int unsigned LAT_DIV  = 12,
    parameter int unsigned LAT_SQRT = 16,
    parameter int unsigned LAT_CVT  = 2,
    parameter int unsigned LAT_MOV  = 1
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [2:0]  issue_ctrl,
    input  logic [4:0]  issue_rs,
    input  logic [4:0]  issue_rt,
    input  logic [4:0]  issue_rd,
    input  logic [15:0] issue_imm,
    input  logic        issue_alu_src,
    input  logic        issue_reg_dst,
    input  logic        flush,
    output logic [2:0]  alu_ctrl,
    output logic [4:0]  alu_rs,
    output logic [4:0]  alu_rt,
    output logic [15:0] alu_imm,
    output logic        alu_src,
    output logic        alu_start,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic        pend_valid,
    output logic [4:0]  pend_dst,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [15:0] imm_q, imm_d;
    logic        src_q, src_d;
    logic [4:0]  dst_q, dst_d;
    logic        accept_s;

    function automatic logic [4:0] lat_of(input logic [2:0] ctrl);
        logic [4:0] lat;
        case (ctrl)
            3'b000, 3'b001: lat = 5'(LAT_ADD);
            3'b010:         lat = 5'(LAT_MUL);
            3'b011:         lat = 5'(LAT_DIV);
            3'b100:         lat = 5'(LAT_SQRT);
            3'b101, 3'b110: lat = 5'(LAT_CVT);
            default:        lat = 5'(LAT_MOV);
        endcase
        return lat;
    endfunction

    // Next-state, handshake and operand-latch logic
    always_comb begin
        issue_ready = ((state_q == ST_IDLE) || (state_q == ST_WB)) && !flush && !reset;
        accept_s    = issue_valid && issue_ready;
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = 1'b0;
        ctrl_d      = ctrl_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        imm_d       = imm_q;
        src_d       = src_q;
        dst_d       = dst_q;

        // Acceptance is only possible in IDLE or WB, so latching here never disturbs EXEC.
        if (accept_s) begin
            ctrl_d  = issue_ctrl;
            rs_d    = issue_rs;
            rt_d    = issue_rt;
            imm_d   = issue_imm;
            src_d   = issue_alu_src;
            dst_d   = issue_reg_dst ? issue_rd : issue_rt;
            cnt_d   = lat_of(issue_ctrl);
            first_d = 1'b1;
        end else begin
            first_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - 5'd1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 5'd1) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_WB: begin
                if (accept_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and held-field registers
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            first_q <= 1'b0;
            ctrl_q  <= 3'd0;
            rs_q    <= 5'd0;
            rt_q    <= 5'd0;
            imm_q   <= 16'd0;
            src_q   <= 1'b0;
            dst_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            ctrl_q  <= ctrl_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            imm_q   <= imm_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
        end
    end

    assign alu_ctrl   = ctrl_q;
    assign alu_rs     = rs_q;
    assign alu_rt     = rt_q;
    assign alu_imm    = imm_q;
    assign alu_src    = src_q;
    assign alu_start  = (state_q == ST_EXEC) && first_q;
    assign reg_write  = (state_q == ST_WB);
    assign write_reg  = dst_q;
    assign pend_dst   = dst_q;
    assign pend_valid = (state_q != ST_IDLE);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer: a cycle-level transaction model predicts start/write
// events and per-cycle held outputs; a negedge monitor pops and compares them.
module tb_fpu_sequencer;

    logic        clk = 1'b1;
    logic        reset, issue_valid, issue_alu_src, issue_reg_dst, flush;
    logic [2:0]  issue_ctrl;
    logic [4:0]  issue_rs, issue_rt, issue_rd;
    logic [15:0] issue_imm;
    logic        issue_ready, alu_src, alu_start, reg_write, pend_valid, busy;
    logic [2:0]  alu_ctrl;
    logic [4:0]  alu_rs, alu_rt, write_reg, pend_dst;
    logic [15:0] alu_imm;

    fpu_sequencer dut (
        .cpu_clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_ctrl(issue_ctrl), .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
        .issue_imm(issue_imm), .issue_alu_src(issue_alu_src), .issue_reg_dst(issue_reg_dst),
        .flush(flush), .alu_ctrl(alu_ctrl), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_imm(alu_imm),
        .alu_src(alu_src), .alu_start(alu_start), .reg_write(reg_write), .write_reg(write_reg),
        .pend_valid(pend_valid), .pend_dst(pend_dst), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [2:0]  ctrl;
        logic [4:0]  rs, rt;
        logic [15:0] imm;
        logic        src;
    } start_t;
    typedef struct {
        int         cyc;
        logic [4:0] dst;
    } wb_t;
    typedef struct {
        bit          chk;
        logic        ready, busy;
        logic [4:0]  dst;
        logic [2:0]  ctrl;
        logic [4:0]  rs, rt;
        logic [15:0] imm;
        logic        src;
    } snap_t;

    start_t start_q[$];
    wb_t    wb_q[$];
    snap_t  snap_q[$];

    int lat_tab[8] = '{3, 3, 5, 12, 16, 2, 2, 1};
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 1;

    // Model state: last cycle an op is pending (its WB cycle) and the held fields
    int          m_wb = 0;
    logic [2:0]  m_ctrl = 3'd0;
    logic [4:0]  m_rs = 5'd0, m_rt = 5'd0, m_dst = 5'd0;
    logic [15:0] m_imm = 16'd0;
    logic        m_src = 1'b0;
    bit          last_acc;

    task automatic drive(input logic v, input logic [2:0] c, input logic [4:0] s, t, d,
                         input logic [15:0] im, input logic sr, rdst, fl, rst);
        snap_t sn;
        logic  exp_ready;
        issue_valid = v; issue_ctrl = c; issue_rs = s; issue_rt = t; issue_rd = d;
        issue_imm = im; issue_alu_src = sr; issue_reg_dst = rdst; flush = fl; reset = rst;
        exp_ready = (cyc >= m_wb) && !fl && !rst;
        sn.chk = (cyc > 1); sn.ready = exp_ready; sn.busy = (cyc <= m_wb); sn.dst = m_dst;
        sn.ctrl = m_ctrl; sn.rs = m_rs; sn.rt = m_rt; sn.imm = m_imm; sn.src = m_src;
        snap_q.push_back(sn);
        last_acc = v && exp_ready;
        if (rst) begin
            if (m_wb > cyc) wb_q.delete(wb_q.size() - 1);
            m_wb = cyc;
            m_ctrl = 3'd0; m_rs = 5'd0; m_rt = 5'd0; m_dst = 5'd0; m_imm = 16'd0; m_src = 1'b0;
        end else if (fl && cyc < m_wb) begin
            wb_q.delete(wb_q.size() - 1);
            m_wb = cyc;
        end else if (last_acc) begin
            m_ctrl = c; m_rs = s; m_rt = t; m_imm = im; m_src = sr;
            m_dst = rdst ? d : t;
            start_q.push_back('{cyc + 1, c, s, t, im, sr});
            wb_q.push_back('{cyc + lat_tab[c] + 1, m_dst});
            m_wb = cyc + lat_tab[c] + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hold_issue(input logic [2:0] c, input logic [4:0] s, t, d,
                              input logic [15:0] im, input logic sr, rdst);
        int n = 0;
        do begin
            drive(1'b1, c, s, t, d, im, sr, rdst, 1'b0, 1'b0);
            n++;
        end while (!last_acc && n < 64);
        n_chk++;
        if (!last_acc) begin
            n_fail++;
            $display("FAIL issue_timeout: not accepted after %0d cycles, required acceptance", n);
        end
    endtask

    // Monitor: compare each cycle's outputs and any start/write events against the scoreboard
    initial begin
        snap_t  s;
        start_t es;
        wb_t    ew;
        forever begin
            @(negedge clk);
            if (snap_q.size() != 0) begin
                s = snap_q.pop_front();
                if (s.chk) begin
                    n_chk++;
                    if (issue_ready !== s.ready) begin
                        n_fail++;
                        $display("FAIL issue_ready cyc=%0d: got %b required %b", cyc, issue_ready, s.ready);
                    end
                    n_chk++;
                    if ({busy, pend_valid} !== {2{s.busy}}) begin
                        n_fail++;
                        $display("FAIL busy_pend cyc=%0d: got busy=%b pend=%b required %b", cyc, busy, pend_valid, s.busy);
                    end
                    n_chk++;
                    if ({write_reg, pend_dst} !== {2{s.dst}}) begin
                        n_fail++;
                        $display("FAIL dst cyc=%0d: got write_reg=%0d pend_dst=%0d required %0d", cyc, write_reg, pend_dst, s.dst);
                    end
                    n_chk++;
                    if ({alu_ctrl, alu_rs, alu_rt, alu_imm, alu_src} !== {s.ctrl, s.rs, s.rt, s.imm, s.src}) begin
                        n_fail++;
                        $display("FAIL alu_fields cyc=%0d: got %h/%h/%h/%h/%b required %h/%h/%h/%h/%b", cyc,
                                 alu_ctrl, alu_rs, alu_rt, alu_imm, alu_src, s.ctrl, s.rs, s.rt, s.imm, s.src);
                    end
                    if (alu_start === 1'b1) begin
                        n_chk++;
                        if (start_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL alu_start cyc=%0d: got unexpected pulse, required none", cyc);
                        end else begin
                            es = start_q.pop_front();
                            if (es.cyc != cyc || {alu_ctrl, alu_rs, alu_rt, alu_imm, alu_src} !== {es.ctrl, es.rs, es.rt, es.imm, es.src}) begin
                                n_fail++;
                                $display("FAIL alu_start cyc=%0d: got pulse ctrl=%h required cyc=%0d ctrl=%h", cyc, alu_ctrl, es.cyc, es.ctrl);
                            end
                        end
                    end
                    while (start_q.size() != 0 && start_q[0].cyc <= cyc) begin
                        es = start_q.pop_front();
                        n_chk++; n_fail++;
                        $display("FAIL alu_start_missing: got no pulse, required pulse at cyc=%0d", es.cyc);
                    end
                    if (reg_write === 1'b1) begin
                        n_chk++;
                        if (wb_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL reg_write cyc=%0d: got unexpected write reg=%0d, required none", cyc, write_reg);
                        end else begin
                            ew = wb_q.pop_front();
                            if (ew.cyc != cyc || write_reg !== ew.dst) begin
                                n_fail++;
                                $display("FAIL reg_write cyc=%0d: got reg=%0d required cyc=%0d reg=%0d", cyc, write_reg, ew.cyc, ew.dst);
                            end
                        end
                    end
                    while (wb_q.size() != 0 && wb_q[0].cyc <= cyc) begin
                        ew = wb_q.pop_front();
                        n_chk++; n_fail++;
                        $display("FAIL reg_write_missing: got no write, required write at cyc=%0d reg=%0d", ew.cyc, ew.dst);
                    end
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic with flush and reset
    initial begin
        logic [2:0]  c;
        logic [4:0]  s, t, d;
        logic [15:0] im;
        logic        sr, rdst;
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        hold_issue(3'b000, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1);
        idle(6);
        hold_issue(3'b100, 5'd4, 5'd7, 5'd9, 16'h1234, 1'b1, 1'b0);
        idle(18);
        hold_issue(3'b010, 5'd5, 5'd6, 5'd8, 16'hbeef, 1'b0, 1'b1);
        hold_issue(3'b111, 5'd10, 5'd11, 5'd12, 16'h0042, 1'b1, 1'b1);
        idle(4);
        hold_issue(3'b011, 5'd13, 5'd14, 5'd15, 16'h0001, 1'b0, 1'b1);
        idle(3);
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        hold_issue(3'b001, 5'd16, 5'd17, 5'd18, 16'h00ff, 1'b0, 1'b1);
        idle(3);
        drive(1'b1, 3'b101, 5'd19, 5'd20, 5'd21, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(3);
        hold_issue(3'b100, 5'd22, 5'd23, 5'd24, 16'haaaa, 1'b1, 1'b0);
        idle(7);
        drive(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        hold_issue(3'b000, 5'd25, 5'd26, 5'd27, 16'h0f0f, 1'b0, 1'b1);
        idle(5);

        c = 3'($urandom); s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
        im = 16'($urandom); sr = 1'($urandom); rdst = 1'($urandom);
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), c, s, t, d, im, sr, rdst,
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 149) == 0));
            if (last_acc) begin
                c = 3'($urandom); s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
                im = 16'($urandom); sr = 1'($urandom); rdst = 1'($urandom);
            end
        end
        idle(20);
        n_chk++;
        if (start_q.size() != 0 || wb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d starts %0d writes outstanding, required 0", start_q.size(), wb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
